pc_flag_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/branch_cond.sv | 27 ++
 rtl/pc_flag_ctrl.sv | 105 ++++++++++
 tb/tb_pc_flag_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle processor: opcodes,
// branch condition codes, PC/flag stage state and small decode helpers.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  function automatic logic writes_zvn(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic writes_z_only(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  // Word offset for B: sign-extended imm9 scaled to bytes.
  function automatic logic [15:0] branch_offset(input logic [8:0] imm9);
    return {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps a 3-bit condition code and the
// registered Z/N/V flags to a taken/not-taken decision.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (ccc)
      CC_NE:     taken = !z;
      CC_EQ:     taken = z;
      CC_GT:     taken = !z && !n;
      CC_LT:     taken = n;
      CC_GTE:    taken = z || (!z && !n);
      CC_LTE:    taken = n || z;
      CC_OVFL:   taken = v;
      CC_UNCOND: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_flag_ctrl.sv
// PC / condition-flag control stage: latches ALU flags, resolves B/BR,
// owns the PC register, the PCS return value and the HLT state.
module pc_flag_ctrl
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic [15:0] rs_data,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        branch_taken,
  output logic        halted
);

  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic        cond_true;
  logic [15:0] b_target;

  state_t      state_q, state_d;
  logic [15:0] pc_d;
  logic        fz_d, fn_d, fv_d;

  assign opcode = instr[15:12];
  assign ccc    = instr[11:9];
  assign imm9   = instr[8:0];

  // Condition is always judged on the registered flags; no alu_* forwarding.
  branch_cond u_branch_cond (
    .ccc   (ccc),
    .z     (flag_z),
    .n     (flag_n),
    .v     (flag_v),
    .taken (cond_true)
  );

  assign pc_plus2 = pc + 16'd2;
  assign b_target = pc_plus2 + branch_offset(imm9);
  assign halted   = (state_q == HALT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    fz_d         = flag_z;
    fn_d         = flag_n;
    fv_d         = flag_v;
    branch_taken = 1'b0;

    unique case (state_q)
      RUN: begin
        branch_taken = ((opcode == OP_B) || (opcode == OP_BR)) && cond_true;
        if (!stall) begin
          if (writes_zvn(opcode)) begin
            fz_d = alu_z;
            fn_d = alu_n;
            fv_d = alu_v;
          end else if (writes_z_only(opcode)) begin
            fz_d = alu_z;
          end

          if (opcode == OP_HLT) begin
            state_d = HALT;
          end else if (opcode == OP_B && cond_true) begin
            pc_d = b_target;
          end else if (opcode == OP_BR && cond_true) begin
            pc_d = rs_data;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      HALT: begin
        // Absorbing: everything frozen until reset, stall ignored.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc      <= RESET_PC;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      flag_z  <= fz_d;
      flag_n  <= fn_d;
      flag_v  <= fv_d;
    end
  end

endmodule

// File: tb/tb_pc_flag_ctrl.sv
// Self-checking bench for pc_flag_ctrl: directed test-plan sequence followed
// by randomized instructions compared against a behavioural model.
module tb_pc_flag_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        alu_z, alu_n, alu_v;
  logic [15:0] rs_data;
  logic        stall;
  logic [15:0] pc, pc_plus2;
  logic        flag_z, flag_n, flag_v;
  logic        branch_taken, halted;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic        m_z, m_n, m_v, m_halt;

  pc_flag_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .alu_z        (alu_z),
    .alu_n        (alu_n),
    .alu_v        (alu_v),
    .rs_data      (rs_data),
    .stall        (stall),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_v       (flag_v),
    .branch_taken (branch_taken),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_holds(input logic [2:0] c, input logic z, input logic n, input logic v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic model_taken(input logic [15:0] i);
    int unsigned op;
    op = i[15:12];
    return !m_halt && (op == 12 || op == 13) && cond_holds(i[11:9], m_z, m_n, m_v);
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_z = 0; m_n = 0; m_v = 0; m_halt = 0;
  endtask

  task automatic model_clock(input logic [15:0] i, input logic az, input logic an,
                             input logic av, input logic [15:0] rs, input logic st);
    int unsigned op;
    int          off;
    int          tgt;
    logic        tk;
    op = i[15:12];
    if (m_halt || st) return;
    tk = model_taken(i);
    if (op == 0 || op == 1) begin
      m_z = az; m_n = an; m_v = av;
    end else if (op == 2 || op == 4 || op == 5 || op == 6) begin
      m_z = az;
    end
    if (op == 15) begin
      m_halt = 1'b1;
    end else if (op == 12 && tk) begin
      off  = (i[8:0] >= 9'd256) ? int'(i[8:0]) - 512 : int'(i[8:0]);
      tgt  = int'(m_pc) + 2 + 2 * off;
      m_pc = 16'(tgt & 32'hFFFF);
    end else if (op == 13 && tk) begin
      m_pc = rs;
    end else begin
      m_pc = 16'((int'(m_pc) + 2) & 32'hFFFF);
    end
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic [15:0] i, input logic az, input logic an,
                      input logic av, input logic [15:0] rs, input logic st);
    logic [15:0] exp_p2;
    instr = i; alu_z = az; alu_n = an; alu_v = av; rs_data = rs; stall = st;
    #2;
    exp_p2 = m_pc + 16'd2;
    check("pc_plus2", pc_plus2, exp_p2);
    check("branch_taken", {15'd0, branch_taken}, {15'd0, model_taken(i)});
    model_clock(i, az, an, av, rs, st);
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("flags", {13'd0, flag_z, flag_n, flag_v}, {13'd0, m_z, m_n, m_v});
    check("halted", {15'd0, halted}, {15'd0, m_halt});
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc", pc, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    check("rst_flags", {13'd0, flag_z, flag_n, flag_v}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [15:0] I_LW     = 16'h8000;
  localparam logic [15:0] I_ADD    = 16'h0000;
  localparam logic [15:0] I_XOR    = 16'h2000;
  localparam logic [15:0] I_BR_UNC = 16'hDE00;
  localparam logic [15:0] I_BR_OVF = 16'hDC00;
  localparam logic [15:0] I_B_EQM2 = 16'hC3FE;
  localparam logic [15:0] I_B_UNC1 = 16'hCE01;
  localparam logic [15:0] I_HLT    = 16'hF000;

  initial begin
    logic [15:0] ri;
    int unsigned halt_age;
    rst_n = 1'b0; instr = I_LW; alu_z = 0; alu_n = 0; alu_v = 0; rs_data = '0; stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 16'h0000);
    check("reset_flags", {13'd0, flag_z, flag_n, flag_v}, 16'h0000);
    check("reset_halted", {15'd0, halted}, 16'h0000);
    rst_n = 1'b1;

    step(I_LW, 0, 0, 0, '0, 0);
    check("first_pc", pc, 16'h0002);

    step(I_ADD, 1, 0, 1, '0, 0);
    check("add_flags", {13'd0, flag_z, flag_n, flag_v}, 16'b101);
    step(I_XOR, 0, 1, 0, '0, 0);
    check("xor_flags", {13'd0, flag_z, flag_n, flag_v}, 16'b001);

    step(I_ADD, 1, 0, 0, '0, 0);
    step(I_BR_UNC, 0, 0, 0, 16'h0010, 0);
    check("br_to_10", pc, 16'h0010);
    instr = I_B_EQM2; #1;
    check("b_eq_taken_comb", {15'd0, branch_taken}, 16'h0001);
    #1;
    step(I_B_EQM2, 0, 0, 0, '0, 0);
    check("b_eq_taken_pc", pc, 16'h000E);
    step(I_ADD, 0, 0, 0, '0, 0);
    step(I_B_EQM2, 0, 0, 0, '0, 0);
    check("b_eq_not_taken_pc", pc, 16'h0012);

    step(I_BR_UNC, 0, 0, 0, 16'hABCD, 0);
    check("br_uncond", pc, 16'hABCD);
    step(I_BR_OVF, 0, 0, 0, 16'h1234, 0);
    check("br_ovfl_not_taken", pc, 16'hABCF);

    step(I_BR_UNC, 0, 0, 0, 16'hFFFE, 0);
    check("wrap_p2", pc_plus2, 16'h0000);
    step(I_LW, 0, 0, 0, '0, 0);
    check("wrap_seq", pc, 16'h0000);
    step(I_BR_UNC, 0, 0, 0, 16'hFFFC, 0);
    step(I_B_UNC1, 0, 0, 0, '0, 0);
    check("wrap_b", pc, 16'h0000);

    step(I_BR_UNC, 0, 0, 0, 16'h0020, 0);
    step(I_HLT, 0, 0, 0, '0, 0);
    check("hlt_halted", {15'd0, halted}, 16'h0001);
    check("hlt_pc", pc, 16'h0020);
    for (int k = 0; k < 10; k++) begin
      step((k % 2) ? I_B_UNC1 : I_ADD, 1, 1, 1, 16'h5555, 1'(k % 3 == 0));
      check("halt_pc_frozen", pc, 16'h0020);
    end
    async_reset();

    halt_age = 0;
    for (int t = 0; t < 600; t++) begin
      ri = 16'($urandom());
      if (ri[15:12] == 4'hF && $urandom_range(0, 7) != 0) ri[15:12] = 4'h8;
      step(ri, 1'($urandom()), 1'($urandom()), 1'($urandom()), 16'($urandom()),
           ($urandom_range(0, 5) == 0));
      if (m_halt) halt_age++;
      if (halt_age > 3) begin
        async_reset();
        halt_age = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
